// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the tick-driven BCD stopwatch.
// Also holds the BCD increment helper that the counter uses.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9;
  localparam int DIGITS_W   = BCD_W * NUM_DIGITS;

  // Ripple-carry BCD increment; MSB of the result is the carry out of the top digit.
  function automatic logic [DIGITS_W:0] bcd_increment(input logic [DIGITS_W-1:0] value);
    logic [DIGITS_W-1:0] result;
    logic                carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (value[i*BCD_W +: BCD_W] == BCD_W'(BCD_MAX)) begin
          result[i*BCD_W +: BCD_W] = {BCD_W{1'b0}};
        end else begin
          result[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end else begin
        result[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W];
      end
    end
    return {carry, result};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, tick-sampled debounce,
// and a registered one-cycle press pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic fastclock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  logic       sync1_r;
  logic       sync2_r;
  logic       level_d_r;
  logic [3:0] agree_r;

  // The counter tracks consecutive tick-samples that disagree with the current level.
  always_ff @(posedge fastclock) begin
    if (reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level     <= 1'b0;
      level_d_r <= 1'b0;
      press     <= 1'b0;
      agree_r   <= 4'd0;
    end else begin
      sync1_r   <= raw;
      sync2_r   <= sync1_r;
      level_d_r <= level;
      press     <= level & ~level_d_r;
      if (tick) begin
        if (sync2_r != level) begin
          if (agree_r == 4'(DEBOUNCE_SAMPLES - 1)) begin
            level   <= ~level;
            agree_r <= 4'd0;
          end else begin
            agree_r <= agree_r + 4'd1;
          end
        end else begin
          agree_r <= 4'd0;
        end
      end else begin
        agree_r <= agree_r;
      end
    end
  end

endmodule

// File: rtl/tick_stopwatch.sv
// Four-digit BCD stopwatch: debounced start/stop and clear buttons drive an
// IDLE/RUN/PAUSE machine; a tick prescaler feeds the BCD counter.
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_COUNT  = 8,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic                fastclock,
  input  logic                reset,
  input  logic                tick,
  input  logic                btn_startstop,
  input  logic                btn_clear,
  output logic [DIGITS_W-1:0] digits,
  output logic                running,
  output logic                overflow
);

  sw_state_t          state_r;
  sw_state_t          state_nxt;
  logic               start_press_s;
  logic               clear_press_s;
  logic               start_level_s;
  logic               clear_level_s;
  logic               unused_levels_s;
  logic               clear_all_s;
  logic               count_en_s;
  logic               wrap_s;
  logic [7:0]         prescaler_r;
  logic [DIGITS_W:0]  inc_s;

  btn_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_start_btn (
    .fastclock (fastclock),
    .reset     (reset),
    .tick      (tick),
    .raw       (btn_startstop),
    .level     (start_level_s),
    .press     (start_press_s)
  );

  btn_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_clear_btn (
    .fastclock (fastclock),
    .reset     (reset),
    .tick      (tick),
    .raw       (btn_clear),
    .level     (clear_level_s),
    .press     (clear_press_s)
  );

  assign unused_levels_s = start_level_s ^ clear_level_s;

  // Next state; clear only acts from PAUSE, where it also beats start/stop.
  always_comb begin
    state_nxt   = state_r;
    clear_all_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_press_s) state_nxt = RUN;
        else               state_nxt = IDLE;
      end
      RUN: begin
        if (start_press_s) state_nxt = PAUSE;
        else               state_nxt = RUN;
      end
      PAUSE: begin
        if (clear_press_s) begin
          state_nxt   = IDLE;
          clear_all_s = 1'b1;
        end else if (start_press_s) begin
          state_nxt = RUN;
        end else begin
          state_nxt = PAUSE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counting is qualified by the pre-edge state, not the next one.
  always_comb begin
    count_en_s = tick & (state_r == RUN);
    wrap_s     = (prescaler_r == 8'(TICKS_PER_COUNT - 1));
    inc_s      = bcd_increment(digits);
  end

  always_ff @(posedge fastclock) begin
    if (reset) begin
      state_r     <= IDLE;
      running     <= 1'b0;
      prescaler_r <= 8'd0;
      digits      <= {DIGITS_W{1'b0}};
      overflow    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      running <= (state_nxt == RUN);
      if (clear_all_s || (state_r == IDLE)) begin
        prescaler_r <= 8'd0;
        digits      <= {DIGITS_W{1'b0}};
        overflow    <= 1'b0;
      end else if (count_en_s) begin
        if (wrap_s) begin
          prescaler_r <= 8'd0;
          digits      <= inc_s[DIGITS_W-1:0];
          overflow    <= overflow | inc_s[DIGITS_W];
        end else begin
          prescaler_r <= prescaler_r + 8'd1;
          digits      <= digits;
          overflow    <= overflow;
        end
      end else begin
        prescaler_r <= prescaler_r;
        digits      <= digits;
        overflow    <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Randomized bench for tick_stopwatch; a cycle-level behavioural model keeps
// the stopwatch value as a plain integer and is compared every cycle.
module tb_tick_stopwatch;

  localparam int TPC = 2;
  localparam int DS  = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic        fastclock = 1'b0;
  logic        reset;
  logic        tick;
  logic        btn_startstop;
  logic        btn_clear;
  logic [15:0] digits;
  logic        running;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_mode = 0;

  // behavioural model state
  bit m_sync1[2], m_sync2[2], m_lvl[2], m_lvl_prev[2], m_press[2];
  int m_run_len[2];
  int m_state, m_pre, m_count;
  bit m_ovf;

  tick_stopwatch #(.TICKS_PER_COUNT(TPC), .DEBOUNCE_SAMPLES(DS)) dut (
    .fastclock     (fastclock),
    .reset         (reset),
    .tick          (tick),
    .btn_startstop (btn_startstop),
    .btn_clear     (btn_clear),
    .digits        (digits),
    .running       (running),
    .overflow      (overflow)
  );

  always #5 fastclock = ~fastclock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_update();
    bit ps, pc, raw[2];
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_sync1[b] = 0; m_sync2[b] = 0; m_lvl[b] = 0; m_lvl_prev[b] = 0;
        m_press[b] = 0; m_run_len[b] = 0;
      end
      m_state = M_IDLE; m_pre = 0; m_count = 0; m_ovf = 0;
      return;
    end
    ps = m_press[0];
    pc = m_press[1];
    if (tick && m_state == M_RUN) begin
      m_pre++;
      if (m_pre == TPC) begin
        m_pre = 0;
        m_count++;
        if (m_count == 10000) begin
          m_count = 0;
          m_ovf = 1;
        end
      end
    end
    case (m_state)
      M_IDLE:  if (ps) m_state = M_RUN;
      M_RUN:   if (ps) m_state = M_PAUSE;
      default: begin
        if (pc) begin
          m_state = M_IDLE; m_count = 0; m_pre = 0; m_ovf = 0;
        end else if (ps) begin
          m_state = M_RUN;
        end
      end
    endcase
    raw[0] = btn_startstop;
    raw[1] = btn_clear;
    for (int b = 0; b < 2; b++) begin
      m_press[b]    = m_lvl[b] && !m_lvl_prev[b];
      m_lvl_prev[b] = m_lvl[b];
      if (tick) begin
        if (m_sync2[b] != m_lvl[b]) begin
          m_run_len[b]++;
          if (m_run_len[b] == DS) begin
            m_lvl[b] = !m_lvl[b];
            m_run_len[b] = 0;
          end
        end else begin
          m_run_len[b] = 0;
        end
      end
      m_sync2[b] = m_sync1[b];
      m_sync1[b] = raw[b];
    end
  endtask

  task automatic step();
    @(negedge fastclock);
    case (tick_mode)
      0:       tick = (cyc % 4 == 0);
      1:       tick = 1'b1;
      default: tick = ($urandom_range(0, 2) == 0);
    endcase
    @(posedge fastclock);
    model_update();
    #1;
    check_eq("digits", 32'(digits), 32'(to_bcd(m_count)));
    check_eq("running", 32'(running), 32'(m_state == M_RUN));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    cyc++;
  endtask

  task automatic press(input bit s, input bit c);
    btn_startstop = s;
    btn_clear     = c;
    repeat (24) step();
    btn_startstop = 1'b0;
    btn_clear     = 1'b0;
    repeat (24) step();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; btn_startstop = 1'b1; btn_clear = 1'b1;
    repeat (3) step();
    check_eq("reset_digits", 32'(digits), 32'h0);
    check_eq("reset_running", 32'(running), 32'h0);
    check_eq("reset_overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    repeat (30) step();
    check_eq("held_start_after_reset", 32'(running), 32'h1);
    btn_startstop = 1'b0; btn_clear = 1'b0;
    repeat (24) step();

    press(1, 0);                       // pause
    press(0, 1);                       // clear back to IDLE
    check_eq("clear_to_idle_digits", 32'(digits), 32'h0);
    check_eq("clear_to_idle_running", 32'(running), 32'h0);

    press(1, 0);                       // run
    repeat (80) step();
    press(0, 1);                       // ignored in RUN
    check_eq("clear_ignored_in_run", 32'(running), 32'h1);
    press(1, 0);                       // pause
    repeat (40) step();
    press(0, 1);
    check_eq("pause_clear_digits", 32'(digits), 32'h0);

    // bounce shorter than the debounce window
    for (int i = 0; i < 12; i++) begin
      btn_startstop = ((i / 4) % 2 == 0);
      step();
    end
    btn_startstop = 1'b0;
    repeat (30) step();
    check_eq("bounce_no_press", 32'(running), 32'h0);

    // simultaneous presses
    press(1, 0);
    press(1, 1);
    check_eq("both_in_run_pauses", 32'(running), 32'h0);
    press(1, 1);
    check_eq("both_in_pause_idle", 32'(digits), 32'h0);

    // tick tied high: press from IDLE coincides with a tick, then wrap
    tick_mode = 1;
    press(1, 0);
    repeat (20100) step();
    check_eq("wrap_overflow", 32'(overflow), 32'h1);
    tick_mode = 0;
    press(1, 0);
    check_eq("overflow_sticky_pause", 32'(overflow), 32'h1);
    press(0, 1);
    check_eq("overflow_cleared", 32'(overflow), 32'h0);

    // randomized segments
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      tick_mode     = $urandom_range(0, 2);
      btn_startstop = $urandom_range(0, 1);
      btn_clear     = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 99) == 0);
      hold = reset ? $urandom_range(1, 3) : $urandom_range(1, 40);
      repeat (hold) step();
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
